// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encoding, the operand-forwarding source encoding and
// the default opcodes used by the controller and its instruction tracking.
package pipe_hazard_ctrl_pkg;

  // Controller state as seen on the debug state output
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  // ALU operand source selection
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_ALU = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  localparam logic [5:0] LOAD_OPC_DEFAULT = 6'd8;
  localparam logic [5:0] NOP_OPC_DEFAULT  = 6'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Producer/consumer register compare.
// Reports whether a tracked producer slot writes the register a consumer
// reads. Register 0 is hard-wired, so a producer targeting it never matches.
// Ports:
//   valid - producer slot holds a real instruction
//   wr    - producer writes the register file
//   rd    - producer destination register
//   rs    - consumer source register
//   match - consumer depends on producer
module hazard_cmp (
  input  logic       valid,
  input  logic       wr,
  input  logic [4:0] rd,
  input  logic [4:0] rs,
  output logic       match
);

  assign match = valid && wr && (rd != 5'd0) && (rd == rs);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller.
// Tracks the instructions in EX and MEM, detects load-use hazards, squashes
// fetch/decode after a taken branch or jump, and selects ALU operand
// forwarding sources for the instruction entering EX.
// Ports:
//   clock, reset                 - clock, asynchronous active-high reset
//   id_valid, id_opcode          - decode-stage instruction
//   id_rs1, id_rs2, id_rd, id_wr - decode-stage register usage
//   ex_branch_taken, ex_jump     - EX-stage control-flow redirect
//   pc_stall, ir_stall           - hold PC / instruction register
//   ex_opc_sel                   - inject NOP_OPC into EX
//   flush                        - squash fetch and decode
//   fwd_sel1, fwd_sel2           - operand sources for the EX instruction
//   state                        - FSM state for debug
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter logic [5:0] LOAD_OPC     = LOAD_OPC_DEFAULT,
  parameter logic [5:0] NOP_OPC      = NOP_OPC_DEFAULT,
  parameter int         FLUSH_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_wr,
  input  logic       ex_branch_taken,
  input  logic       ex_jump,
  output logic       pc_stall,
  output logic       ir_stall,
  output logic       ex_opc_sel,
  output logic       flush,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2,
  output logic [1:0] state
);

  // The FLUSH state itself squashes FLUSH_CYCLES-1 cycles; the redirect
  // cycle accounts for the first one.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t     cur_state;
  logic [1:0] counter;

  logic       ex_valid, ex_wr, ex_is_load;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_wr;
  logic [4:0] mem_rd;

  fwd_t fwd1_q, fwd2_q;
  fwd_t fwd1_d, fwd2_d;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic redirect, load_use, issue;

  hazard_cmp u_cmp_ex_rs1 (
    .valid(ex_valid), .wr(ex_wr), .rd(ex_rd), .rs(id_rs1), .match(ex_m1)
  );
  hazard_cmp u_cmp_ex_rs2 (
    .valid(ex_valid), .wr(ex_wr), .rd(ex_rd), .rs(id_rs2), .match(ex_m2)
  );
  hazard_cmp u_cmp_mem_rs1 (
    .valid(mem_valid), .wr(mem_wr), .rd(mem_rd), .rs(id_rs1), .match(mem_m1)
  );
  hazard_cmp u_cmp_mem_rs2 (
    .valid(mem_valid), .wr(mem_wr), .rd(mem_rd), .rs(id_rs2), .match(mem_m2)
  );

  // A redirect seen while flushing comes from a bubble in EX and is ignored.
  // Load-use only matters in RUN: STALL already resolved it and FLUSH only
  // has bubbles ahead of decode.
  assign redirect = (ex_branch_taken || ex_jump) && (cur_state != ST_FLUSH);
  assign load_use = (cur_state == ST_RUN) && id_valid && ex_is_load &&
                    (ex_m1 || ex_m2);

  assign flush      = redirect || ((cur_state == ST_FLUSH) && (counter != 2'd0));
  assign pc_stall   = load_use && !redirect;
  assign ir_stall   = load_use && !redirect;
  assign ex_opc_sel = load_use || flush;

  // A real instruction moves into EX this cycle
  assign issue = id_valid && !ex_opc_sel;

  assign state    = cur_state;
  assign fwd_sel1 = fwd1_q;
  assign fwd_sel2 = fwd2_q;

  // Forwarding sources for the instruction entering EX. A load still in EX
  // cannot forward its data yet; that case is covered by the stall.
  always_comb begin
    fwd1_d = FWD_REG;
    fwd2_d = FWD_REG;
    if (issue) begin
      if (ex_m1 && !ex_is_load) fwd1_d = FWD_ALU;
      else if (mem_m1)          fwd1_d = FWD_MEM;
      if (ex_m2 && !ex_is_load) fwd2_d = FWD_ALU;
      else if (mem_m2)          fwd2_d = FWD_MEM;
    end
  end

  // Control FSM with flush counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= ST_RUN;
      counter   <= 2'd0;
    end else begin
      case (cur_state)
        ST_RUN: begin
          if (redirect) begin
            cur_state <= ST_FLUSH;
            counter   <= FLUSH_INIT;
          end else if (load_use) begin
            cur_state <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (redirect) begin
            cur_state <= ST_FLUSH;
            counter   <= FLUSH_INIT;
          end else begin
            cur_state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (counter == 2'd0) cur_state <= ST_RUN;
          else                 counter   <= counter - 2'd1;
        end
        default: begin
          cur_state <= ST_RUN;
          counter   <= 2'd0;
        end
      endcase
    end
  end

  // EX/MEM tracking and registered forwarding selects. An instruction that
  // decodes as the bubble opcode is treated as non-writing so it can never
  // act as a forwarding producer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_wr      <= 1'b0;
      ex_is_load <= 1'b0;
      ex_rd      <= 5'd0;
      mem_valid  <= 1'b0;
      mem_wr     <= 1'b0;
      mem_rd     <= 5'd0;
      fwd1_q     <= FWD_REG;
      fwd2_q     <= FWD_REG;
    end else begin
      mem_valid  <= ex_valid;
      mem_wr     <= ex_wr;
      mem_rd     <= ex_rd;
      ex_valid   <= issue;
      ex_wr      <= issue && id_wr && (id_opcode != NOP_OPC);
      ex_is_load <= issue && (id_opcode == LOAD_OPC);
      ex_rd      <= issue ? id_rd : 5'd0;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_wr;
  logic       ex_branch_taken, ex_jump;
  logic       pc_stall, ir_stall, ex_opc_sel, flush;
  logic [1:0] fwd_sel1, fwd_sel2, state;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [5:0] OPC_ADD  = 6'd1;
  localparam logic [5:0] OPC_LOAD = 6'd8;

  pipe_hazard_ctrl #(
    .LOAD_OPC(6'd8), .NOP_OPC(6'd0), .FLUSH_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_wr(id_wr),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_stall(pc_stall), .ir_stall(ir_stall), .ex_opc_sel(ex_opc_sel),
    .flush(flush), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .state(state)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  // Drive one cycle of decode/EX inputs at the falling edge, then settle
  task automatic applyStimulus(input logic v, input logic [5:0] opc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic wr,
                               input logic br, input logic jmp);
    @(negedge clock);
    id_valid        = v;
    id_opcode       = opc;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_rd           = rd;
    id_wr           = wr;
    ex_branch_taken = br;
    ex_jump         = jmp;
    #1;
  endtask

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Directed scenario sequence
  initial begin
    reset = 1'b1;
    id_valid = 1'b0; id_opcode = 6'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rd = 5'd0; id_wr = 1'b0; ex_branch_taken = 1'b0; ex_jump = 1'b0;
    #12;
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_outs", {28'd0, pc_stall, ir_stall, ex_opc_sel, flush}, 32'd0);
    checkOutput("reset_fwd", {28'd0, fwd_sel1, fwd_sel2}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // ADD r3 ; SUB r5,r3,r4 ; ADD r9,r3,r5
    applyStimulus(1'b1, OPC_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("add_no_stall", 32'(pc_stall), 32'd0);
    applyStimulus(1'b1, OPC_ADD, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("sub_no_stall", {30'd0, pc_stall, ex_opc_sel}, 32'd0);
    applyStimulus(1'b1, OPC_ADD, 5'd3, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
    checkOutput("sub_fwd1_alu", 32'(fwd_sel1), 32'd1);
    checkOutput("sub_fwd2_reg", 32'(fwd_sel2), 32'd0);
    idle();
    checkOutput("add9_fwd1_mem", 32'(fwd_sel1), 32'd2);
    checkOutput("add9_fwd2_alu", 32'(fwd_sel2), 32'd1);
    idle();
    checkOutput("bubble_fwd", {28'd0, fwd_sel1, fwd_sel2}, 32'd0);

    // LOAD r7 ; ADD r8,r2,r7 with one stall cycle
    applyStimulus(1'b1, OPC_LOAD, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("load_no_stall", 32'(pc_stall), 32'd0);
    applyStimulus(1'b1, OPC_ADD, 5'd2, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_stalls", {28'd0, pc_stall, ir_stall, ex_opc_sel, flush}, 32'b1110);
    checkOutput("lu_state_run", 32'(state), 32'd0);
    applyStimulus(1'b1, OPC_ADD, 5'd2, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_state", 32'(state), 32'd1);
    checkOutput("stall_outs", {29'd0, pc_stall, ir_stall, ex_opc_sel}, 32'd0);
    checkOutput("stall_bubble_fwd", {28'd0, fwd_sel1, fwd_sel2}, 32'd0);

    // LOAD r0 followed by a use of r0
    applyStimulus(1'b1, OPC_LOAD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_back_run", 32'(state), 32'd0);
    checkOutput("lu_fwd1_reg", 32'(fwd_sel1), 32'd0);
    checkOutput("lu_fwd2_mem", 32'(fwd_sel2), 32'd2);
    applyStimulus(1'b1, OPC_ADD, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    checkOutput("r0_no_stall", {30'd0, pc_stall, ex_opc_sel}, 32'd0);

    // Taken branch: two flush cycles, then a jump ignored while flushing
    applyStimulus(1'b1, OPC_ADD, 5'd10, 5'd1, 5'd11, 1'b1, 1'b1, 1'b0);
    checkOutput("r0_fwd", {28'd0, fwd_sel1, fwd_sel2}, 32'd0);
    checkOutput("br_outs", {28'd0, pc_stall, ir_stall, ex_opc_sel, flush}, 32'b0011);
    checkOutput("br_state", 32'(state), 32'd0);
    applyStimulus(1'b1, OPC_ADD, 5'd10, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0);
    checkOutput("fl1_state", 32'(state), 32'd2);
    checkOutput("fl1_outs", {30'd0, ex_opc_sel, flush}, 32'b11);
    applyStimulus(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("fl0_state", 32'(state), 32'd2);
    checkOutput("fl0_jump_ignored", {30'd0, ex_opc_sel, flush}, 32'd0);
    checkOutput("fl_bubble_fwd", {28'd0, fwd_sel1, fwd_sel2}, 32'd0);

    // Load-use and jump together: redirect wins
    applyStimulus(1'b1, OPC_LOAD, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("fl_exit_run", 32'(state), 32'd0);
    applyStimulus(1'b1, OPC_ADD, 5'd2, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1);
    checkOutput("lu_jmp_outs", {28'd0, pc_stall, ir_stall, ex_opc_sel, flush}, 32'b0011);
    idle();
    checkOutput("lu_jmp_state", 32'(state), 32'd2);
    checkOutput("lu_jmp_fl1", 32'(flush), 32'd1);

    // Asynchronous reset in FLUSH with counter=1
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_outs", {28'd0, pc_stall, ir_stall, ex_opc_sel, flush}, 32'd0);
    checkOutput("async_rst_state", 32'(state), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_state", 32'(state), 32'd0);

    // Old producers are gone; only a new producer forwards
    applyStimulus(1'b1, OPC_ADD, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_no_stall", 32'(pc_stall), 32'd0);
    applyStimulus(1'b1, OPC_ADD, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_fwd_clear", {28'd0, fwd_sel1, fwd_sel2}, 32'd0);
    idle();
    checkOutput("post_rst_fwd1_alu", 32'(fwd_sel1), 32'd1);
    checkOutput("post_rst_fwd2_reg", 32'(fwd_sel2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
